// File: rtl/byte_serializer.sv
// byte_serializer
//   Turns a stream of pixel bytes into single-bit strobes for a
//   WS2812-style waveform generator. After the last byte of a frame, it
//   holds the line low for a programmable latch time. It then pulses
//   frame_done_o.
//
//   Buffering: an 8-bit holding register feeds an 8-bit shift register.
//   This lets upstream deliver the next byte while the current one is
//   still shifting out.
//
//   Configuration macro:
//     SERIALIZER_LSB_FIRST_EN  defined   -> bits leave LSB first
//                              undefined -> bits leave MSB first (WS2812 order)
//
// Ports
//   clk_i           system clock, rising edge
//   rst_i           asynchronous active-high reset
//   byte_vld_i      upstream byte valid
//   byte_data_i     pixel byte (G/R/B component)
//   byte_last_i     byte is last of frame (qualified by byte_vld_i)
//   byte_rdy_o      holding register empty; accept on byte_vld_i & byte_rdy_o
//   reg_rst_time_i  latch time in clk cycles, sampled when LATCH is entered
//   bit_rdy_i       downstream ready for the next bit
//   bit_vld_o       one-cycle bit strobe
//   bit_data_o      bit value, valid with bit_vld_o, held otherwise
//   frame_done_o    one-cycle pulse at the end of the latch time

module byte_serializer #(
    parameter int RST_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     byte_vld_i,
    input  logic [7:0]               byte_data_i,
    input  logic                     byte_last_i,
    output logic                     byte_rdy_o,
    input  logic [RST_CNT_WIDTH-1:0] reg_rst_time_i,
    input  logic                     bit_rdy_i,
    output logic                     bit_vld_o,
    output logic                     bit_data_o,
    output logic                     frame_done_o
);

`ifdef SERIALIZER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_WAIT,
        ST_LATCH
    } state_t;

    state_t state, next_state;

    // Holding register
    logic       hold_full;
    logic [7:0] hold_data;
    logic       hold_last;

    // Shift register
    logic [7:0] shift_data;
    logic       shift_last;
    logic [2:0] bit_cnt;

    // Value presented on bit_data_o between strobes
    logic       bit_q;

    // Latch timing
    logic                     latch_run;  // bit_rdy_i has been seen; counting
    logic [RST_CNT_WIDTH-1:0] latch_cnt;
    logic [RST_CNT_WIDTH-1:0] rst_time_q;

    // Control decoded from the FSM
    logic load_en;
    logic advance;
    logic latch_enter;
    logic latch_start;
    logic accept;
    logic hold_full_next;
    logic cur_bit;

    assign accept  = byte_vld_i & byte_rdy_o;
    assign cur_bit = LSB_FIRST ? shift_data[0] : shift_data[7];

    // A byte arriving on the same edge that LOAD empties the holding register
    // takes its place, so the register stays full and byte_rdy_o stays low.
    assign hold_full_next = accept | (hold_full & ~load_en);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        next_state   = state;
        bit_vld_o    = 1'b0;
        frame_done_o = 1'b0;
        load_en      = 1'b0;
        advance      = 1'b0;
        latch_enter  = 1'b0;
        latch_start  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (hold_full) next_state = ST_LOAD;
            end

            ST_LOAD: begin
                load_en    = 1'b1;
                next_state = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (bit_rdy_i) begin
                    bit_vld_o  = 1'b1;
                    next_state = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Downstream must drop ready to acknowledge the strobe.
                if (!bit_rdy_i) begin
                    if (bit_cnt != 3'd7) begin
                        advance    = 1'b1;
                        next_state = ST_SHIFT;
                    end else if (shift_last) begin
                        latch_enter = 1'b1;
                        next_state  = ST_LATCH;
                    end else if (hold_full) begin
                        next_state = ST_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end

            ST_LATCH: begin
                // Counting starts in the first cycle ready is seen (count 0).
                // latch_cnt then holds the number of cycles since that one.
                if (latch_run) begin
                    if (latch_cnt == rst_time_q) begin
                        frame_done_o = 1'b1;
                        next_state   = ST_IDLE;
                    end
                end else if (bit_rdy_i) begin
                    if (rst_time_q == '0) begin
                        frame_done_o = 1'b1;
                        next_state   = ST_IDLE;
                    end else begin
                        latch_start = 1'b1;
                    end
                end
            end

            default: next_state = ST_IDLE;
        endcase

        bit_data_o = bit_vld_o ? cur_bit : bit_q;
    end

    // ------------------------------------------------------------------
    // Holding register and byte_rdy_o
    // ------------------------------------------------------------------
    // NOTE: the data registers are reset along with the control flags.
    // They are only eight bits, and clearing them makes the post-reset
    // state fully deterministic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_full  <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            byte_rdy_o <= 1'b0;
        end else begin
            hold_full  <= hold_full_next;
            byte_rdy_o <= ~hold_full_next;
            if (accept) begin
                hold_data <= byte_data_i;
                hold_last <= byte_last_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shift register, bit counter and held bit value
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_data <= '0;
            shift_last <= 1'b0;
            bit_cnt    <= '0;
            bit_q      <= 1'b0;
        end else begin
            if (load_en) begin
                shift_data <= hold_data;
                shift_last <= hold_last;
                bit_cnt    <= '0;
            end else if (advance) begin
                bit_cnt    <= bit_cnt + 3'd1;
                shift_data <= LSB_FIRST ? {1'b0, shift_data[7:1]}
                                        : {shift_data[6:0], 1'b0};
            end
            if (bit_vld_o) bit_q <= cur_bit;
        end
    end

    // ------------------------------------------------------------------
    // Latch timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            latch_run  <= 1'b0;
            latch_cnt  <= '0;
            rst_time_q <= '0;
        end else begin
            if (latch_enter) begin
                rst_time_q <= reg_rst_time_i;
                latch_run  <= 1'b0;
                latch_cnt  <= '0;
            end else if (latch_start) begin
                latch_run <= 1'b1;
                latch_cnt <= RST_CNT_WIDTH'(1);
            end else if (frame_done_o) begin
                latch_run <= 1'b0;
            end else if (latch_run) begin
                latch_cnt <= latch_cnt + RST_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer
//   Scoreboard bench for byte_serializer. Each accepted byte pushes its
//   eight expected bits, and every strobe pops and compares one. A
//   downstream model drives bit_rdy_i: it drops ready the cycle after a
//   strobe and raises it again a programmable number of cycles later.

module tb_byte_serializer;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         byte_vld_i = 1'b0;
    logic [7:0]   byte_data_i = '0;
    logic         byte_last_i = 1'b0;
    logic         byte_rdy_o;
    logic [W-1:0] reg_rst_time_i = '0;
    logic         bit_rdy_i = 1'b0;
    logic         bit_vld_o;
    logic         bit_data_o;
    logic         frame_done_o;

    byte_serializer #(.RST_CNT_WIDTH(W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .byte_vld_i     (byte_vld_i),
        .byte_data_i    (byte_data_i),
        .byte_last_i    (byte_last_i),
        .byte_rdy_o     (byte_rdy_o),
        .reg_rst_time_i (reg_rst_time_i),
        .bit_rdy_i      (bit_rdy_i),
        .bit_vld_o      (bit_vld_o),
        .bit_data_o     (bit_data_o),
        .frame_done_o   (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard and monitor state
    bit exp_q[$];
    int strobe_count = 0;
    int last_strobe_cyc = 0;
    int done_count = 0;
    int done_cyc = 0;
    bit prev_vld = 1'b0;
    bit strobe_seen = 1'b0;

    // Downstream model control
    int rdy_mode = 0;   // 0: ready held low, 1: handshake with rdy_gap
    int rdy_gap = 1;
    int gap_cnt = 0;
    int last_rise_cyc = 0;

    int acc_cyc = 0;

    // Expected emission order of a byte
    task automatic push_bits(input logic [7:0] d);
        logic [7:0] v;
        v = d;
        for (int i = 0; i < 8; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            exp_q.push_back(v[i]);
`else
            exp_q.push_back(v[7-i]);
`endif
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk_i) begin
        if (bit_vld_o === 1'b1) begin
            bit e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got bit %0b, none expected (cycle %0d)", bit_data_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (prev_vld || bit_data_o !== e) begin
                    errors++;
                    $display("FAIL strobe_data: got bit %0b prev_vld %0b, expected bit %0b prev_vld 0 (cycle %0d)",
                             bit_data_o, prev_vld, e, cyc);
                end
            end
            strobe_count++;
            last_strobe_cyc = cyc;
            strobe_seen = 1'b1;
        end
        prev_vld = (bit_vld_o === 1'b1);
        if (frame_done_o === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    // Downstream model: drop ready the cycle after a strobe, re-raise rdy_gap later
    always @(posedge clk_i) begin
        #1;
        if (rdy_mode == 0) begin
            bit_rdy_i = 1'b0;
            gap_cnt = 0;
        end else if (strobe_seen) begin
            bit_rdy_i = 1'b0;
            gap_cnt = rdy_gap;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
            if (gap_cnt == 0) begin
                bit_rdy_i = 1'b1;
                last_rise_cyc = cyc;
            end
        end else if (!bit_rdy_i) begin
            bit_rdy_i = 1'b1;
            last_rise_cyc = cyc;
        end
        strobe_seen = 1'b0;
    end

    // Offer one byte and wait (bounded) until it is accepted
    task automatic send_byte(input logic [7:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        byte_vld_i = 1'b1;
        byte_data_i = d;
        byte_last_i = last;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk_i);
            if (byte_rdy_o === 1'b1) begin
                @(posedge clk_i);
                #1;
                ok = 1'b1;
                acc_cyc = cyc;
                push_bits(d);
            end
        end
        byte_vld_i = 1'b0;
        byte_last_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %02h not accepted, expected acceptance", d);
        end
    endtask

    // Wait (bounded) until strobe_count reaches target
    task automatic wait_strobes(input int target, input string name);
        int n;
        n = 0;
        while (strobe_count < target && n < 2000) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        if (strobe_count < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: strobes %0d, expected %0d", name, strobe_count, target);
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_count < target && n < 2000) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        if (done_count < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: frame_done count %0d, expected %0d", name, done_count, target);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d bits left, expected 0", name, exp_q.size());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({byte_rdy_o, bit_vld_o, bit_data_o, frame_done_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: rdy/vld/data/done %b, expected 0000",
                     {byte_rdy_o, bit_vld_o, bit_data_o, frame_done_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (byte_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_before_edge: byte_rdy_o %b, expected 0", byte_rdy_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (byte_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy_after_edge: byte_rdy_o %b, expected 1", byte_rdy_o);
        end
    endtask

    task automatic test_latency();
        int base;
        rdy_mode = 1;
        rdy_gap = 1;
        idle(3);
        base = strobe_count;
        send_byte(8'h5A, 1'b0);
        wait_strobes(base + 1, "latency");
        checks++;
        if (last_strobe_cyc != acc_cyc + 2) begin
            errors++;
            $display("FAIL latency: first strobe %0d cycles after accept, expected 2",
                     last_strobe_cyc - acc_cyc);
        end
        wait_strobes(base + 8, "latency_byte");
        idle(5);
        check_queue_empty("latency");
    endtask

    task automatic test_slow_downstream();
        int base, dbase;
        rdy_mode = 1;
        rdy_gap = 5;
        base = strobe_count;
        dbase = done_count;
        send_byte(8'hA5, 1'b0);
        wait_strobes(base + 8, "slow");
        idle(20);
        checks++;
        if (strobe_count != base + 8 || done_count != dbase) begin
            errors++;
            $display("FAIL slow_counts: strobes %0d done %0d, expected strobes 8 done 0",
                     strobe_count - base, done_count - dbase);
        end
        check_queue_empty("slow");
    endtask

    task automatic test_back_to_back();
        int base, dbase;
        rdy_mode = 1;
        rdy_gap = 1;
        reg_rst_time_i = W'(10);
        base = strobe_count;
        dbase = done_count;
        send_byte(8'hFF, 1'b0);
        @(negedge clk_i);
        checks++;
        if (byte_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rdy_first: byte_rdy_o %b with holding full, expected 0", byte_rdy_o);
        end
        send_byte(8'h00, 1'b1);
        repeat (3) @(negedge clk_i);
        checks++;
        if (byte_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rdy_second: byte_rdy_o %b with holding full, expected 0", byte_rdy_o);
        end
        wait_strobes(base + 16, "b2b");
        wait_done(dbase + 1, "b2b");
        checks++;
        if (done_cyc - last_rise_cyc != 10) begin
            errors++;
            $display("FAIL b2b_latch_time: frame_done %0d cycles after ready rise, expected 10",
                     done_cyc - last_rise_cyc);
        end
        idle(20);
        checks++;
        if (done_count != dbase + 1 || strobe_count != base + 16) begin
            errors++;
            $display("FAIL b2b_counts: done %0d strobes %0d, expected done 1 strobes 16",
                     done_count - dbase, strobe_count - base);
        end
        check_queue_empty("b2b");
    endtask

    task automatic test_zero_latch();
        int base, dbase;
        rdy_mode = 1;
        rdy_gap = 1;
        reg_rst_time_i = '0;
        base = strobe_count;
        dbase = done_count;
        send_byte(8'h96, 1'b1);
        wait_strobes(base + 8, "zero_latch");
        wait_done(dbase + 1, "zero_latch");
        checks++;
        if (done_cyc != last_rise_cyc) begin
            errors++;
            $display("FAIL zero_latch_time: frame_done %0d cycles after ready rise, expected 0",
                     done_cyc - last_rise_cyc);
        end
        idle(10);
        checks++;
        if (done_count != dbase + 1 || byte_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_latch_idle: done %0d rdy %b, expected done 1 rdy 1",
                     done_count - dbase, byte_rdy_o);
        end
        check_queue_empty("zero_latch");
    endtask

    task automatic test_reset_mid_byte();
        int base, dbase;
        rdy_mode = 1;
        rdy_gap = 1;
        reg_rst_time_i = W'(4);
        base = strobe_count;
        dbase = done_count;
        send_byte(8'hC3, 1'b1);
        wait_strobes(base + 3, "midrst");
        rst_i = 1'b1;
        #1;
        checks++;
        if ({byte_rdy_o, bit_vld_o, bit_data_o, frame_done_o} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_outputs: rdy/vld/data/done %b, expected 0000",
                     {byte_rdy_o, bit_vld_o, bit_data_o, frame_done_o});
        end
        exp_q.delete();
        idle(3);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(30);
        checks++;
        if (strobe_count != base + 3 || done_count != dbase) begin
            errors++;
            $display("FAIL midrst_quiet: strobes %0d done %0d, expected strobes 3 done 0",
                     strobe_count - base, done_count - dbase);
        end
        send_byte(8'h3C, 1'b0);
        wait_strobes(base + 11, "midrst_next");
        idle(10);
        check_queue_empty("midrst");
    endtask

    task automatic test_stall();
        int base;
        bit seen_rdy;
        rdy_mode = 0;
        idle(2);
        base = strobe_count;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        seen_rdy = 1'b0;
        byte_vld_i = 1'b1;
        byte_data_i = 8'h33;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (byte_rdy_o !== 1'b0) seen_rdy = 1'b1;
        end
        @(posedge clk_i);
        #1;
        byte_vld_i = 1'b0;
        checks++;
        if (seen_rdy || strobe_count != base) begin
            errors++;
            $display("FAIL stall_hold: rdy_seen %b strobes %0d, expected rdy_seen 0 strobes 0",
                     seen_rdy, strobe_count - base);
        end
        rdy_mode = 1;
        rdy_gap = 1;
        wait_strobes(base + 16, "stall_drain");
        idle(20);
        checks++;
        if (strobe_count != base + 16) begin
            errors++;
            $display("FAIL stall_count: strobes %0d, expected 16", strobe_count - base);
        end
        check_queue_empty("stall");
    endtask

    task automatic test_bit_order();
        int base;
        rdy_mode = 1;
        rdy_gap = 2;
        base = strobe_count;
        send_byte(8'h01, 1'b0);
        wait_strobes(base + 8, "order");
        idle(5);
        check_queue_empty("order");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_slow_downstream();
        test_back_to_back();
        test_zero_latch();
        test_reset_mid_byte();
        test_stall();
        test_bit_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter: RST_CNT_WIDTH, default 16, width of the latch/reset-time counter and reg_rst_time_i.
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 byte_vld_i  input  1  upstream byte valid.
REQ-005 byte_data_i  input  8  pixel byte (G/R/B component).
REQ-006 byte_last_i  input  1  byte is last of frame; qualified by byte_vld_i.
REQ-007 byte_rdy_o  output  1  holding register empty; byte accepted when byte_vld_i & byte_rdy_o.
REQ-008 reg_rst_time_i  input  RST_CNT_WIDTH  latch (line-low) time after frame, in clk cycles; sampled on entry to LATCH.
REQ-009 bit_rdy_i  input  1  downstream waveform generator ready for next bit.
REQ-010 bit_vld_o  output  1  one-cycle bit strobe to waveform generator.
REQ-011 bit_data_o  output  1  bit value, valid when bit_vld_o=1.
REQ-012 frame_done_o  output  1  one-cycle pulse at end of latch time.

Function
REQ-013 Two-stage buffering SHALL be used: 8-bit holding register (+last flag) and 8-bit shift register (+last flag, 3-bit bit counter).
REQ-014 byte_rdy_o SHALL be registered, 1 iff holding register empty; holding register SHALL accept a byte in any state incl. LATCH.
REQ-015 States SHALL be IDLE, LOAD, SHIFT, WAIT, LATCH.
REQ-016 IDLE: holding full -> LOAD.
REQ-017 LOAD (1 cycle): holding -> shift register, counter=0, holding marked empty -> SHIFT.
REQ-018 SHIFT: when bit_rdy_i=1, drive bit_vld_o=1 for exactly one cycle with bit_data_o=current bit -> WAIT; bit_rdy_i=0 -> stay, bit_vld_o=0.
REQ-019 WAIT: stay until bit_rdy_i sampled 0, then: counter<7 -> increment, SHIFT; counter=7 and byte last -> LATCH (wait for bit_rdy_i=1 before counting); counter=7, not last, holding full -> LOAD; else -> IDLE.
REQ-020 LATCH: after bit_rdy_i=1, count reg_rst_time_i cycles with bit_vld_o=0, then pulse frame_done_o one cycle -> IDLE; reg_rst_time_i=0 -> frame_done_o in the first cycle bit_rdy_i=1 is seen.
REQ-021 Latency: byte accepted at edge N, state IDLE, bit_rdy_i=1 -> bit_vld_o high after edge N+2.
REQ-022 bit_vld_o SHALL never be high two consecutive cycles; bit_data_o holds its value outside strobes.
REQ-023 Simultaneous LOAD and byte accept: holding register SHALL take the new byte the same edge it is emptied; byte_rdy_o stays 0 with no byte lost or duplicated.
REQ-024 Each accepted byte SHALL produce exactly 8 strobes, in order.

Reset
REQ-025 rst_i=1 SHALL immediately force state IDLE, buffers empty, counters 0, bit_vld_o=0, bit_data_o=0, frame_done_o=0, byte_rdy_o=0.
REQ-026 byte_rdy_o SHALL rise the first clock edge after rst_i deasserts.
REQ-027 Reset mid-byte or mid-LATCH SHALL discard partial data; no frame_done_o pulse.

Configuration
REQ-028 Macro SERIALIZER_LSB_FIRST_EN defined: bits emitted LSB first; undefined (default): MSB first (WS2812 order).

Verification
REQ-029 Byte 0xA5 not last, downstream model drops bit_rdy_i 1 cycle after strobe, re-raises 5 cycles later -> bit_data_o 1,0,1,0,0,1,0,1; no frame_done_o.
REQ-030 Bytes 0xFF, 0x00(last) back-to-back, reg_rst_time_i=10 -> 16 strobes 8x1 then 8x0, byte_rdy_o low while holding full, frame_done_o exactly 10 cycles after final bit_rdy_i rise.
REQ-031 One last byte, reg_rst_time_i=0 -> frame_done_o in cycle final bit_rdy_i rise is sampled; returns IDLE.
REQ-032 rst_i asserted after 3rd strobe of 0xC3 -> outputs 0 within same cycle, no further strobes, no frame_done_o; next byte after release serialized fully.
REQ-033 bit_rdy_i held 0, two bytes offered -> bit_vld_o stays 0, first byte into shift register, second held, byte_rdy_o=0, third not accepted.
REQ-034 SERIALIZER_LSB_FIRST_EN defined, byte 0x01 -> bit_data_o 1,0,0,0,0,0,0,0.
